// File: rtl/gpio_bank_pio.sv
// GPIO bank with synchronized and debounced inputs, set/clear outputs and edge-capture interrupt.
// Memory-mapped register slave with a fixed read latency of one cycle.
module gpio_bank_pio #(
    parameter int unsigned          IN_WIDTH        = 6,
    parameter int unsigned          OUT_WIDTH       = 32,
    parameter int unsigned          DEBOUNCE_CYCLES = 50000,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           avs_address,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    input  logic                 avs_read,
    output logic [31:0]          avs_readdata,
    input  logic [IN_WIDTH-1:0]  gpio_in,
    output logic [OUT_WIDTH-1:0] gpio_out,
    output logic                 irq
);

    localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd2;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

    logic [IN_WIDTH-1:0]  sync1_q, sync1_d;
    logic [IN_WIDTH-1:0]  sync2_q, sync2_d;
    logic [IN_WIDTH-1:0]  db_q, db_d;
    logic [CNT_W-1:0]     cnt_q [IN_WIDTH];
    logic [CNT_W-1:0]     cnt_d [IN_WIDTH];
    logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic [IN_WIDTH-1:0]  irq_mask_q, irq_mask_d;
    logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d;
    logic [IN_WIDTH-1:0]  rise_en_q, rise_en_d;
    logic [IN_WIDTH-1:0]  fall_en_q, fall_en_d;
    logic [31:0]          readdata_q, readdata_d;
    logic                 irq_q, irq_d;

    logic [IN_WIDTH-1:0]  wr_in;
    logic [OUT_WIDTH-1:0] wr_out;
    logic [IN_WIDTH-1:0]  w1c;
    logic [IN_WIDTH-1:0]  capture;
    logic                 unused_wdata;

    assign wr_in        = avs_writedata[IN_WIDTH-1:0];
    assign wr_out       = avs_writedata[OUT_WIDTH-1:0];
    assign unused_wdata = ^avs_writedata;

    always_comb begin
        sync1_d    = gpio_in;
        sync2_d    = sync1_q;
        db_d       = db_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        readdata_d = readdata_q;
        w1c        = '0;

        // Counter runs only while the synced bit disagrees with the debounced bit.
        for (int i = 0; i < int'(IN_WIDTH); i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        if (avs_write) begin
            case (avs_address)
                ADDR_DATA_OUT: data_out_d = wr_out;
                ADDR_OUT_SET:  data_out_d = data_out_q | wr_out;
                ADDR_OUT_CLR:  data_out_d = data_out_q & ~wr_out;
                ADDR_IRQ_MASK: irq_mask_d = wr_in;
                ADDR_EDGE_CAP: w1c        = wr_in;
                ADDR_RISE_EN:  rise_en_d  = wr_in;
                ADDR_FALL_EN:  fall_en_d  = wr_in;
                default:       ;
            endcase
        end

        // A fresh capture overrides a same-cycle clear of the same bit.
        capture    = (db_d & ~db_q & rise_en_q) | (~db_d & db_q & fall_en_q);
        edge_cap_d = (edge_cap_q & ~w1c) | capture;
        irq_d      = |(edge_cap_q & irq_mask_q);

        if (avs_read) begin
            case (avs_address)
                ADDR_DATA_IN:  readdata_d = 32'(db_q);
                ADDR_DATA_OUT: readdata_d = 32'(data_out_q);
                ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
                ADDR_EDGE_CAP: readdata_d = 32'(edge_cap_q);
                ADDR_RISE_EN:  readdata_d = 32'(rise_en_q);
                ADDR_FALL_EN:  readdata_d = 32'(fall_en_q);
                default:       readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            cnt_q      <= '{default: '0};
            data_out_q <= OUT_RESET;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign gpio_out     = data_out_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_bank_pio.sv
// Directed bench for gpio_bank_pio: a default-width instance and a narrow IN=1/OUT=8 instance.
module tb_gpio_bank_pio;

    logic        clk = 1'b0;
    logic        reset;

    logic [2:0]  addr, addr_w;
    logic        wr, wr_w, rd, rd_w;
    logic [31:0] wdata, wdata_w;
    logic [31:0] rdata, rdata_w;
    logic [5:0]  gin;
    logic [0:0]  gin_w;
    logic [31:0] gout;
    logic [7:0]  gout_w;
    logic        irq, irq_w;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] rv;

    always #5 clk = ~clk;

    gpio_bank_pio #(
        .IN_WIDTH(6), .OUT_WIDTH(32), .DEBOUNCE_CYCLES(4), .OUT_RESET(32'h5)
    ) u_dut (
        .clk(clk), .reset(reset),
        .avs_address(addr), .avs_write(wr), .avs_writedata(wdata),
        .avs_read(rd), .avs_readdata(rdata),
        .gpio_in(gin), .gpio_out(gout), .irq(irq)
    );

    gpio_bank_pio #(
        .IN_WIDTH(1), .OUT_WIDTH(8), .DEBOUNCE_CYCLES(4), .OUT_RESET(8'h0)
    ) u_dut_w (
        .clk(clk), .reset(reset),
        .avs_address(addr_w), .avs_write(wr_w), .avs_writedata(wdata_w),
        .avs_read(rd_w), .avs_readdata(rdata_w),
        .gpio_in(gin_w), .gpio_out(gout_w), .irq(irq_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        if (sel) begin addr_w = a; wdata_w = d; wr_w = 1'b1; end
        else     begin addr   = a; wdata   = d; wr   = 1'b1; end
        @(negedge clk);
        wr = 1'b0; wr_w = 1'b0;
    endtask

    task automatic bus_rd(input bit sel, input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        if (sel) begin addr_w = a; rd_w = 1'b1; end
        else     begin addr   = a; rd   = 1'b1; end
        @(negedge clk);
        rd = 1'b0; rd_w = 1'b0;
        d = sel ? rdata_w : rdata;
    endtask

    initial begin
        reset = 1'b1;
        addr = '0; wr = 1'b0; wdata = '0; rd = 1'b0; gin = '0;
        addr_w = '0; wr_w = 1'b0; wdata_w = '0; rd_w = 1'b0; gin_w = '0;
        repeat (3) @(negedge clk);
        chk("reset_gpio_out", gout, 32'h5);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_readdata", rdata, 32'h0);
        reset = 1'b0;

        bus_rd(0, 3'd1, rv); chk("reset_data_out_rd", rv, 32'h5);
        bus_rd(0, 3'd5, rv); chk("reset_edge_cap_rd", rv, 32'h0);

        // Bus ops: direct write, set, clear
        bus_wr(0, 3'd1, 32'h0000_00F0); chk("wr_data_out", gout, 32'h0000_00F0);
        bus_wr(0, 3'd2, 32'h0000_000F); chk("out_set", gout, 32'h0000_00FF);
        bus_wr(0, 3'd3, 32'h0000_0030); chk("out_clr", gout, 32'h0000_00CF);
        bus_rd(0, 3'd1, rv); chk("rd_data_out", rv, 32'h0000_00CF);
        bus_rd(0, 3'd2, rv); chk("rd_out_set_zero", rv, 32'h0);
        bus_rd(0, 3'd3, rv); chk("rd_out_clr_zero", rv, 32'h0);

        // Simultaneous read and write returns the pre-write value
        @(negedge clk);
        addr = 3'd1; wdata = 32'h0000_0012; wr = 1'b1; rd = 1'b1;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        chk("rdwr_old_value", rdata, 32'h0000_00CF);
        chk("rdwr_new_out", gout, 32'h0000_0012);

        // Debounce: 3-cycle glitch is rejected
        @(negedge clk); gin[0] = 1'b1;
        repeat (3) @(negedge clk);
        gin[0] = 1'b0;
        repeat (10) @(negedge clk);
        bus_rd(0, 3'd0, rv); chk("glitch_data_in", rv, 32'h0);

        // Steady rise: debounced at edge 6, visible in readdata after edge 7
        @(negedge clk); gin[0] = 1'b1; addr = 3'd0; rd = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("rise_data_in_k%0d", k), rdata, (k >= 7) ? 32'h1 : 32'h0);
        end
        rd = 1'b0;
        bus_rd(0, 3'd5, rv); chk("no_cap_rise_disabled", rv, 32'h0);
        @(negedge clk); gin[0] = 1'b0;
        repeat (10) @(negedge clk);

        // Edge capture and irq
        bus_wr(0, 3'd6, 32'h1);
        bus_wr(0, 3'd4, 32'h1);
        @(negedge clk); gin[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("irq_before", 32'(irq), 32'h0);
        @(negedge clk);
        chk("irq_after_cap", 32'(irq), 32'h1);
        bus_rd(0, 3'd5, rv); chk("edge_cap_rise", rv, 32'h1);
        bus_wr(0, 3'd5, 32'h1);
        chk("irq_hold_after_w1c", 32'(irq), 32'h1);
        @(negedge clk);
        chk("irq_clear", 32'(irq), 32'h0);
        bus_rd(0, 3'd5, rv); chk("edge_cap_cleared", rv, 32'h0);
        @(negedge clk); gin[0] = 1'b0;
        repeat (10) @(negedge clk);
        bus_rd(0, 3'd5, rv); chk("no_cap_fall", rv, 32'h0);
        chk("irq_no_fall", 32'(irq), 32'h0);

        // Collision: W1C of bit 2 in the same cycle as its falling capture
        bus_wr(0, 3'd7, 32'h4);
        @(negedge clk); gin[2] = 1'b1;
        repeat (10) @(negedge clk);
        bus_rd(0, 3'd5, rv); chk("no_cap_rise_bit2", rv, 32'h0);
        @(negedge clk); gin[2] = 1'b0;
        repeat (5) @(negedge clk);
        addr = 3'd5; wdata = 32'h4; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        bus_rd(0, 3'd5, rv); chk("collision_cap_wins", rv, 32'h4);

        // Reset mid-debounce
        bus_wr(0, 3'd4, 32'h4);
        @(negedge clk);
        chk("irq_bit2", 32'(irq), 32'h1);
        bus_wr(0, 3'd1, 32'hFFFF_FFFF); chk("out_all_ones", gout, 32'hFFFF_FFFF);
        bus_rd(0, 3'd5, rv); chk("edge_cap_pre_reset", rv, 32'h4);
        @(negedge clk); gin[0] = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; addr = 3'd0; rd = 1'b1;
        chk("rst_gpio_out", gout, 32'h5);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_readdata", rdata, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("rst_restart_k%0d", k), rdata, (k >= 7) ? 32'h1 : 32'h0);
        end
        rd = 1'b0;
        bus_rd(0, 3'd5, rv); chk("rst_edge_cap", rv, 32'h0);
        bus_rd(0, 3'd4, rv); chk("rst_irq_mask", rv, 32'h0);

        // Narrow instance: width truncation and zero extension
        bus_wr(1, 3'd1, 32'hFFFF_FFFF); chk("w_gpio_out", 32'(gout_w), 32'h0000_00FF);
        bus_rd(1, 3'd1, rv); chk("w_data_out_rd", rv, 32'h0000_00FF);
        @(negedge clk); gin_w = 1'b1;
        repeat (10) @(negedge clk);
        bus_rd(1, 3'd0, rv); chk("w_data_in_rd", rv, 32'h1);
        bus_wr(1, 3'd7, 32'hFFFF_FFFF);
        bus_rd(1, 3'd7, rv); chk("w_fall_en_rd", rv, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_bank_pio.md
GPIO_BANK_PIO -- requirements
Module: gpio_bank_pio

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 6: number of input pins, legal range 1..32.
REQ-002 SHALL have parameter OUT_WIDTH, default 32: number of output pins, legal range 1..32.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50000: stable-time threshold in clk cycles, minimum 1.
REQ-004 SHALL have parameter OUT_RESET, default 0: reset value of the output register, OUT_WIDTH bits.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port avs_address, input, 3 bits: word address.
REQ-008 SHALL have port avs_write, input, 1 bit: write strobe.
REQ-009 SHALL have port avs_writedata, input, 32 bits: write data.
REQ-010 SHALL have port avs_read, input, 1 bit: read strobe.
REQ-011 SHALL have port avs_readdata, output, 32 bits: registered read data.
REQ-012 SHALL have port gpio_in, input, IN_WIDTH bits: asynchronous external pins.
REQ-013 SHALL have port gpio_out, output, OUT_WIDTH bits: driven directly from the output register.
REQ-014 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-015 SHALL pass each gpio_in bit through a 2-flop synchronizer before any other use.
REQ-016 SHALL keep a per-bit debounce counter; it clears whenever the synced bit equals the debounced bit, otherwise increments.
REQ-017 SHALL load the synced bit into the debounced bit when its counter reaches DEBOUNCE_CYCLES-1 while still differing, and clear that counter in the same cycle.
REQ-018 SHALL give a total pin-to-debounced latency of 2 + DEBOUNCE_CYCLES cycles; a glitch shorter than DEBOUNCE_CYCLES cycles causes no change.
REQ-019 SHALL define the register map as follows:
- 0 DATA_IN (RO): debounced inputs.
- 1 DATA_OUT (RW).
- 2 OUT_SET (WO): write-1 sets bits.
- 3 OUT_CLR (WO): write-1 clears bits.
- 4 IRQ_MASK (RW).
- 5 EDGE_CAP (RO, write-1-to-clear).
- 6 RISE_EN (RW).
- 7 FALL_EN (RW).
REQ-020 SHALL zero-extend all reads to 32 bits, ignore writedata bits above the register width, and return 0 on reads of registers 2 and 3.
REQ-021 SHALL update avs_readdata one cycle after avs_read is sampled high and hold it until the next read; there is no waitrequest and read latency is fixed at 1.
REQ-022 SHALL let a write take effect on the cycle after avs_write is sampled high; gpio_out reflects the new value one cycle after the write.
REQ-023 SHALL set EDGE_CAP[i] on a debounced 0->1 transition when RISE_EN[i]=1, and on a debounced 1->0 transition when FALL_EN[i]=1.
REQ-024 SHALL make a capture win over a same-cycle W1C of the same EDGE_CAP bit, leaving the bit set.
REQ-025 SHALL register irq as OR(EDGE_CAP & IRQ_MASK), so irq asserts one cycle after the capture bit sets and deasserts one cycle after the clear or unmask.
REQ-026 SHALL not affect the synchronizer, debounce or capture logic when a register read or write occurs in the same cycle as an edge.
REQ-027 SHALL treat avs_read and avs_write asserted together as both performed: read returns the pre-write value.

Reset
REQ-028 SHALL, while reset=1 at a clock edge, load the following, overriding any same-cycle bus access:
- DATA_OUT = OUT_RESET.
- IRQ_MASK, EDGE_CAP, RISE_EN and FALL_EN = 0.
- Debounced bits, synchronizers and counters = 0.
- avs_readdata = 0; irq = 0.
REQ-029 SHALL apply reset mid-debounce by discarding partial counts; pins held high through reset become debounced 1 after 2 + DEBOUNCE_CYCLES cycles, capturing only if RISE_EN has been set by then.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-030 SHALL cover a bus-ops scenario: write DATA_OUT=0x0000_00F0, OUT_SET=0x0F, OUT_CLR=0x30 -> gpio_out=0x0000_00CF; reading DATA_OUT returns 0x0000_00CF one cycle after avs_read.
REQ-031 SHALL cover a debounce scenario: gpio_in[0] pulses high for 3 cycles, then later holds high -> DATA_IN stays 0 after the pulse and reads 1 exactly 6 cycles after the steady rise.
REQ-032 SHALL cover an edge/irq scenario: with RISE_EN=0x1 and IRQ_MASK=0x1, raise gpio_in[0] -> EDGE_CAP=0x1 and irq=1 one cycle later; write EDGE_CAP=0x1 -> irq=0 after one cycle; a falling edge causes no capture.
REQ-033 SHALL cover a collision scenario: W1C of EDGE_CAP bit 2 in the same cycle as a new falling-edge capture on bit 2 (FALL_EN=0x4) -> EDGE_CAP[2] remains 1.
REQ-034 SHALL cover a reset scenario: assert reset mid-debounce with gpio_out=0xFFFF_FFFF, OUT_RESET=0x5 -> next cycle gpio_out=0x5, irq=0, EDGE_CAP=0, and the count restarts.
REQ-035 SHALL cover a width scenario: with IN_WIDTH=1 and OUT_WIDTH=8, write 0xFFFF_FFFF to DATA_OUT -> readback 0x0000_00FF, and DATA_IN bits [31:1] read 0.
